dense_layer_seq_mac: RTL and testbench

- Sequential, parametrised fully-connected layer engine for the hand-written inference path.
- Accepts one input vector of N_IN fixed-point activations and streams out N_OUT results.
- Each result is the bias plus the dot product of the inputs with that output's weight row.
- Weights and biases come from external read-only memories (the per-layer generated weight/bias tables) through a fixed 1-cycle-latency read port; width, fractional bits, layer shape and activation are all parameters.

---
 rtl/dense_layer_seq_mac.sv | 199 +++++++++++++++++++
 tb/tb_dense_layer_seq_mac.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_seq_mac.sv
// Sequential fully-connected layer: buffers one activation vector, then computes
// bias + dot(row, inputs) per output with one multiply-accumulate per cycle.
module dense_layer_seq_mac #(
    parameter int W     = 9,
    parameter int NFRAC = 4,
    parameter int N_IN  = 32,
    parameter int N_OUT = 32,
    parameter int RELU  = 1,
    parameter int ACC_W = 2*W + $clog2(N_IN) + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [W-1:0]                    in_data,
    output logic                            w_rd_en,
    output logic [$clog2(N_IN*N_OUT)-1:0]   w_addr,
    input  logic [W-1:0]                    w_data,
    output logic                            b_rd_en,
    output logic [$clog2(N_OUT)-1:0]        b_addr,
    input  logic [W-1:0]                    b_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [W-1:0]                    out_data,
    output logic [$clog2(N_OUT)-1:0]        out_idx,
    output logic                            out_last,
    output logic                            busy
);

    localparam int AW = $clog2(N_IN*N_OUT);
    localparam int OW = $clog2(N_OUT);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic signed [ACC_W-1:0] HALF = $signed({{(ACC_W-1){1'b0}}, 1'b1}) <<< (NFRAC-1);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2**(W-1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(2**(W-1)));

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BIAS,
        MAC,
        DRAIN,
        EMIT
    } state_t;

    state_t                   state;
    state_t                   state_nx;
    logic [IW-1:0]            i_cnt;
    logic [OW-1:0]            o_cnt;
    logic [W-1:0]             in_buf [N_IN];
    logic signed [ACC_W-1:0]  acc;

    logic                     cnt_last;
    logic                     o_last;
    logic [IW-1:0]            op_idx;
    logic [W-1:0]             op_a;
    logic signed [2*W-1:0]    prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  rnd;
    logic [W-1:0]             sat;
    logic [W-1:0]             act;

    assign cnt_last = (i_cnt == IW'(N_IN-1));
    assign o_last   = (o_cnt == OW'(N_OUT-1));

    // in_ready is gated by rst_n so every output reads 0 while reset is held
    assign in_ready = rst_n && ((state == IDLE) || (state == LOAD));
    assign busy     = (state != IDLE);
    assign b_addr   = o_cnt;
    assign out_idx  = o_cnt;
    assign out_last = out_valid && o_last;
    assign w_addr   = AW'(o_cnt) * AW'(N_IN) + AW'(i_cnt);

    // Product operand lags the issued weight address by one cycle (memory latency)
    assign op_idx   = (state == DRAIN) ? IW'(N_IN-1) : (i_cnt - IW'(1));
    assign op_a     = in_buf[op_idx];
    assign prod     = $signed({{W{op_a[W-1]}}, op_a}) * $signed({{W{w_data[W-1]}}, w_data});
    assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    assign acc_sum  = acc + prod_ext;
    assign bias_ext = $signed({{(ACC_W-W){b_data[W-1]}}, b_data}) <<< NFRAC;

    always_comb begin
        rnd = (acc_sum + HALF) >>> NFRAC;
        if (rnd > MAXV) begin
            sat = MAXV[W-1:0];
        end else if (rnd < MINV) begin
            sat = MINV[W-1:0];
        end else begin
            sat = rnd[W-1:0];
        end
        if ((RELU != 0) && sat[W-1]) begin
            act = '0;
        end else begin
            act = sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        w_rd_en   = 1'b0;
        b_rd_en   = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = (N_IN == 1) ? BIAS : LOAD;
                end
            end
            LOAD: begin
                if (in_valid && cnt_last) begin
                    state_nx = BIAS;
                end
            end
            BIAS: begin
                b_rd_en  = 1'b1;
                state_nx = MAC;
            end
            MAC: begin
                w_rd_en = 1'b1;
                if (cnt_last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = o_last ? IDLE : BIAS;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt    <= '0;
            o_cnt    <= '0;
            acc      <= '0;
            out_data <= '0;
            for (int k = 0; k < N_IN; k++) begin
                in_buf[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_buf[0] <= in_data;
                        i_cnt     <= (N_IN == 1) ? IW'(0) : IW'(1);
                        o_cnt     <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        in_buf[i_cnt] <= in_data;
                        i_cnt         <= cnt_last ? '0 : (i_cnt + IW'(1));
                    end
                end
                BIAS: begin
                    i_cnt <= '0;
                end
                MAC: begin
                    acc <= (i_cnt == '0) ? bias_ext : acc_sum;
                    if (!cnt_last) begin
                        i_cnt <= i_cnt + IW'(1);
                    end
                end
                DRAIN: begin
                    acc      <= acc_sum;
                    out_data <= act;
                end
                EMIT: begin
                    if (out_ready) begin
                        o_cnt <= o_last ? '0 : (o_cnt + OW'(1));
                    end
                end
                default: begin
                    i_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_seq_mac.sv
// Bench for dense_layer_seq_mac: 4x2 linear and 4x2 ReLU engines in lockstep,
// plus a 32x32 ReLU engine, against a plain-integer reference model.
module tb_dense_layer_seq_mac;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    logic       sel = 1'b0;
    logic       drv_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [8:0] in_data = '0;
    logic       mon_en = 1'b0;
    logic       in_valid_s, in_valid_c;
    assign in_valid_s = drv_valid & ~sel;
    assign in_valid_c = drv_valid & sel;

    logic       in_ready_a, w_rd_en_a, b_rd_en_a, out_valid_a, out_last_a, busy_a;
    logic [2:0] w_addr_a;
    logic [0:0] b_addr_a, out_idx_a;
    logic [8:0] out_data_a, w_data_a, b_data_a;
    logic       in_ready_b, w_rd_en_b, b_rd_en_b, out_valid_b, out_last_b, busy_b;
    logic [2:0] w_addr_b;
    logic [0:0] b_addr_b, out_idx_b;
    logic [8:0] out_data_b, w_data_b, b_data_b;
    logic       in_ready_c, w_rd_en_c, b_rd_en_c, out_valid_c, out_last_c, busy_c;
    logic [9:0] w_addr_c;
    logic [4:0] b_addr_c, out_idx_c;
    logic [8:0] out_data_c, w_data_c, b_data_c;

    dense_layer_seq_mac #(.W(9), .NFRAC(4), .N_IN(4), .N_OUT(2), .RELU(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_a), .in_data(in_data),
        .w_rd_en(w_rd_en_a), .w_addr(w_addr_a), .w_data(w_data_a),
        .b_rd_en(b_rd_en_a), .b_addr(b_addr_a), .b_data(b_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_idx(out_idx_a), .out_last(out_last_a), .busy(busy_a));

    dense_layer_seq_mac #(.W(9), .NFRAC(4), .N_IN(4), .N_OUT(2), .RELU(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_b), .in_data(in_data),
        .w_rd_en(w_rd_en_b), .w_addr(w_addr_b), .w_data(w_data_b),
        .b_rd_en(b_rd_en_b), .b_addr(b_addr_b), .b_data(b_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_idx(out_idx_b), .out_last(out_last_b), .busy(busy_b));

    dense_layer_seq_mac #(.W(9), .NFRAC(4), .N_IN(32), .N_OUT(32), .RELU(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data),
        .w_rd_en(w_rd_en_c), .w_addr(w_addr_c), .w_data(w_data_c),
        .b_rd_en(b_rd_en_c), .b_addr(b_addr_c), .b_data(b_data_c),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .out_idx(out_idx_c), .out_last(out_last_c), .busy(busy_c));

    // Shared weight/bias tables with 1-cycle read latency
    logic [8:0] wmem [1024];
    logic [8:0] bmem [32];
    always @(posedge clk) begin
        if (w_rd_en_a) w_data_a <= wmem[{7'd0, w_addr_a}];
        if (b_rd_en_a) b_data_a <= bmem[{4'd0, b_addr_a}];
        if (w_rd_en_b) w_data_b <= wmem[{7'd0, w_addr_b}];
        if (b_rd_en_b) b_data_b <= bmem[{4'd0, b_addr_b}];
        if (w_rd_en_c) w_data_c <= wmem[w_addr_c];
        if (b_rd_en_c) b_data_c <= bmem[b_addr_c];
    end

    logic       cur_in_ready, cur_out_valid, cur_busy, cur_w_rd_en, cur_b_rd_en, cur_out_last;
    logic [9:0] cur_w_addr;
    logic [4:0] cur_b_addr, cur_out_idx;
    logic [8:0] cur_out_data;
    assign cur_in_ready  = sel ? in_ready_c  : in_ready_a;
    assign cur_out_valid = sel ? out_valid_c : out_valid_a;
    assign cur_busy      = sel ? busy_c      : busy_a;
    assign cur_w_rd_en   = sel ? w_rd_en_c   : w_rd_en_a;
    assign cur_b_rd_en   = sel ? b_rd_en_c   : b_rd_en_a;
    assign cur_out_last  = sel ? out_last_c  : out_last_a;
    assign cur_w_addr    = sel ? w_addr_c    : {7'd0, w_addr_a};
    assign cur_b_addr    = sel ? b_addr_c    : {4'd0, b_addr_a};
    assign cur_out_idx   = sel ? out_idx_c   : {4'd0, out_idx_a};
    assign cur_out_data  = sel ? out_data_c  : out_data_a;

    int total = 0;
    int bad = 0;
    int n_in = 4;
    int n_out = 2;
    logic [8:0]  in_vec [32];
    logic [8:0]  exp_a [32];
    logic [8:0]  exp_b [32];
    logic [15:0] rd_log [$];
    logic [15:0] exp_q [$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (cur_w_rd_en) rd_log.push_back({6'd0, cur_w_addr});
            if (cur_b_rd_en) rd_log.push_back(16'h8000 | {11'd0, cur_b_addr});
        end
    end

    typedef struct {
        logic [3:0][8:0] in_v;
        logic [7:0][8:0] w_v;
        logic [1:0][8:0] b_v;
        logic [1:0][8:0] e_lin;
        logic [1:0][8:0] e_relu;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: bias scaled to the product format, exact dot product, round half up
    // by flooring (acc+half)/2^NFRAC, saturate to 9 bits, optional clamp at zero.
    function automatic logic [8:0] model(input int o, input bit relu);
        int acc;
        int r;
        acc = int'($signed(bmem[o])) * 16;
        for (int i = 0; i < n_in; i++) begin
            acc += int'($signed(in_vec[i])) * int'($signed(wmem[o*n_in + i]));
        end
        r = (acc + 8) >>> 4;
        if (r > 255) r = 255;
        if (r < -256) r = -256;
        if (relu && r < 0) r = 0;
        return r[8:0];
    endfunction

    task automatic load_tbl(input int t);
        for (int i = 0; i < 4; i++) in_vec[i] = tbl[t].in_v[i];
        for (int k = 0; k < 8; k++) wmem[k] = tbl[t].w_v[k];
        for (int o = 0; o < 2; o++) begin
            bmem[o]  = tbl[t].b_v[o];
            exp_a[o] = tbl[t].e_lin[o];
            exp_b[o] = tbl[t].e_relu[o];
        end
    endtask

    // Called and returns just after a rising edge
    task automatic send_vec(input int bubble_max);
        for (int k = 0; k < n_in; k++) begin
            int guard;
            drv_valid = 1'b0;
            repeat ($urandom_range(0, bubble_max)) begin
                in_data = 9'($urandom);
                @(posedge clk); #1;
            end
            drv_valid = 1'b1;
            in_data = in_vec[k];
            guard = 0;
            while (!cur_in_ready && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            check("in_ready_wait", {31'd0, cur_in_ready}, 1);
            @(posedge clk); #1;
            if (k == 0) check("busy_load", {31'd0, cur_busy}, 1);
        end
        drv_valid = 1'b0;
        in_data = 9'($urandom);
    endtask

    // Each result is expected N_IN+3 falling edges after the previous handshake edge,
    // i.e. N_IN+2 cycles after the cycle that follows that handshake.
    task automatic recv(input int stall_o, input int stall_len);
        for (int o = 0; o < n_out; o++) begin
            int cnt;
            int idle_seen;
            out_ready = (o == stall_o) ? 1'b0 : 1'b1;
            cnt = 0;
            idle_seen = 0;
            do begin
                @(negedge clk);
                cnt++;
                if (!cur_busy) idle_seen++;
            end while (!cur_out_valid && cnt < 200);
            check("latency", cnt, n_in + 3);
            check("busy_run", idle_seen, 0);
            check("out_data", {23'd0, cur_out_data}, {23'd0, exp_a[o]});
            check("out_idx", {27'd0, cur_out_idx}, o);
            check("out_last", {31'd0, cur_out_last}, (o == n_out - 1) ? 1 : 0);
            if (!sel) check("out_relu", {23'd0, out_data_b}, {23'd0, exp_b[o]});
            if (o == stall_o) begin
                repeat (stall_len) begin
                    @(negedge clk);
                    check("stall_hold", {17'd0, cur_out_valid, cur_out_idx, cur_out_data},
                          {17'd0, 1'b1, 5'(o), exp_a[o]});
                    check("stall_rd", {30'd0, cur_w_rd_en, cur_b_rd_en}, 0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            check("valid_drop", {31'd0, cur_out_valid}, 0);
        end
        check("idle_end", {31'd0, cur_busy}, 0);
    endtask

    task automatic run_vec(input int bubble_max, input int stall_o, input int stall_len);
        int errs;
        rd_log.delete();
        exp_q.delete();
        for (int o = 0; o < n_out; o++) begin
            exp_q.push_back(16'h8000 | 16'(o));
            for (int i = 0; i < n_in; i++) exp_q.push_back(16'(o*n_in + i));
        end
        mon_en = 1'b1;
        send_vec(bubble_max);
        recv(stall_o, stall_len);
        mon_en = 1'b0;
        errs = 0;
        for (int k = 0; k < exp_q.size() && k < rd_log.size(); k++) begin
            if (rd_log[k] !== exp_q[k]) errs++;
        end
        check("rd_count", rd_log.size(), exp_q.size());
        check("rd_seq", errs, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cnt;
        tbl[0].in_v = {4{9'h010}};
        tbl[0].w_v  = {{4{9'h1F8}}, {4{9'h008}}};
        tbl[0].b_v  = {9'h000, 9'h004};
        tbl[0].e_lin = {9'h1E0, 9'h024};
        tbl[0].e_relu = {9'h000, 9'h024};
        tbl[1].in_v = {9'h000, 9'h000, 9'h000, 9'h001};
        tbl[1].w_v  = {8{9'h008}};
        tbl[1].b_v  = {9'h000, 9'h000};
        tbl[1].e_lin = {9'h001, 9'h001};
        tbl[1].e_relu = {9'h001, 9'h001};
        tbl[2].in_v = {9'h000, 9'h000, 9'h000, 9'h1FF};
        tbl[2].w_v  = {8{9'h008}};
        tbl[2].b_v  = {9'h000, 9'h000};
        tbl[2].e_lin = {9'h000, 9'h000};
        tbl[2].e_relu = {9'h000, 9'h000};
        tbl[3].in_v = {4{9'h0FF}};
        tbl[3].w_v  = {{4{9'h100}}, {4{9'h0FF}}};
        tbl[3].b_v  = {9'h000, 9'h000};
        tbl[3].e_lin = {9'h100, 9'h0FF};
        tbl[3].e_relu = {9'h000, 9'h0FF};

        for (int k = 0; k < 1024; k++) wmem[k] = '0;
        for (int k = 0; k < 32; k++) bmem[k] = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", {12'd0, in_ready_a, w_rd_en_a, w_addr_a, b_rd_en_a, b_addr_a, out_valid_a,
                          out_data_a, out_idx_a, out_last_a, busy_a}, 0);
        check("reset_b", {12'd0, in_ready_b, w_rd_en_b, w_addr_b, b_rd_en_b, b_addr_b, out_valid_b,
                          out_data_b, out_idx_b, out_last_b, busy_b}, 0);
        check("reset_c_ctl", {26'd0, in_ready_c, w_rd_en_c, b_rd_en_c, out_valid_c, out_last_c, busy_c}, 0);
        check("reset_c_dat", {3'd0, w_addr_c, b_addr_c, out_data_c, out_idx_c}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", {30'd0, busy_a, in_ready_a}, 1);

        // Directed table: nominal with bubbles and a 10-cycle stall, rounding, saturation
        for (int t = 0; t < 4; t++) begin
            load_tbl(t);
            run_vec((t == 0) ? 3 : 0, (t == 0) ? 0 : -1, 10);
        end

        // Reset during MAC of output 1
        load_tbl(0);
        send_vec(0);
        out_ready = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid_a && cnt < 200);
        check("rst_pre_out", {23'd0, out_data_a}, 32'h024);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rst_in_mac", {28'd0, w_rd_en_a, w_addr_a}, {28'd0, 1'b1, 3'd5});
        rst_n = 1'b0;
        #1;
        check("rst_outs_a", {12'd0, in_ready_a, w_rd_en_a, w_addr_a, b_rd_en_a, b_addr_a, out_valid_a,
                             out_data_a, out_idx_a, out_last_a, busy_a}, 0);
        check("rst_outs_b", {12'd0, in_ready_b, w_rd_en_b, w_addr_b, b_rd_en_b, b_addr_b, out_valid_b,
                             out_data_b, out_idx_b, out_last_b, busy_b}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_idle", {30'd0, busy_a, in_ready_a}, 1);
        run_vec(0, -1, 0);

        // Randomized 4x2 vectors against the model
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 4; i++) in_vec[i] = 9'($urandom);
            for (int k = 0; k < 8; k++) wmem[k] = 9'($urandom);
            for (int o = 0; o < 2; o++) bmem[o] = 9'($urandom);
            for (int o = 0; o < 2; o++) begin
                exp_a[o] = model(o, 1'b0);
                exp_b[o] = model(o, 1'b1);
            end
            run_vec(2, $urandom_range(0, 2), $urandom_range(1, 5));
        end

        // Default 32x32 geometry
        sel = 1'b1;
        n_in = 32;
        n_out = 32;
        @(posedge clk); #1;
        for (int it = 0; it < 2; it++) begin
            for (int i = 0; i < 32; i++) in_vec[i] = 9'($urandom_range(0, 511) >> (it * 3));
            for (int k = 0; k < 1024; k++) wmem[k] = 9'($urandom);
            for (int o = 0; o < 32; o++) bmem[o] = 9'($urandom);
            for (int o = 0; o < 32; o++) exp_a[o] = model(o, 1'b1);
            run_vec(1, $urandom_range(0, 31), 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
